// File: rtl/tt_um_shift_reg.sv
// -----------------------------------------------------------------------------
// tt_um_shift_reg
//   4-bit universal shift register wrapped as a Tiny Tapeout user project.
//   It can load a 4-bit value in parallel, or shift right or left with a
//   serial input bit filling the vacated position.
//
// Ports
//   clk      in   system clock; all state changes on its rising edge
//   reset    in   synchronous, active-high; clears the register
//   ena      in   design-selected; when low the register holds its value
//   ui_in    in   [0]=load, [1]=direction (0=right, 1=left), [2]=serial_in,
//                 [6:3]=parallel_data, [7]=unused
//   uo_out   out  [3:0]=q, [4]=serial_out, [7:5]=0
//   uio_in   in   unused
//   uio_out  out  constant 0
//   uio_oe   out  constant 0 (all bidirectional pins are inputs)
// -----------------------------------------------------------------------------
module tt_um_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic             load;
  logic             direction;
  logic             serial_in;
  logic [WIDTH-1:0] parallel_data;
  logic [WIDTH-1:0] q_p0;
  logic             serial_out;

  assign load          = ui_in[0];
  assign direction     = ui_in[1];
  assign serial_in     = ui_in[2];
  assign parallel_data = ui_in[6:3];

  // Pins with no function; gathered here so their lack of use is deliberate.
  logic unused_pins;
  assign unused_pins = &{1'b0, ui_in[7], uio_in};

  // Register stage: reset > hold (ena low) > load > shift.
  // There is no shift enable: with load low and ena high it shifts every edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_p0 <= '0;
    end else if (ena) begin
      if (load) begin
        q_p0 <= parallel_data;
      end else if (direction) begin
        q_p0 <= {q_p0[WIDTH-2:0], serial_in};
      end else begin
        q_p0 <= {serial_in, q_p0[WIDTH-1:1]};
      end
    end
  end

  // The bit the next shift in the current direction will discard.
  assign serial_out = direction ? q_p0[WIDTH-1] : q_p0[0];

  assign uo_out  = {3'b000, serial_out, q_p0};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_shift_reg.sv
module tb_tt_um_shift_reg;

  logic       clk = 1'b0;
  logic       reset;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int errors = 0;
  int checks = 0;

  logic [7:0] sb_q[$];
  logic [7:0] exp_byte;
  logic [7:0] got_byte;
  logic [3:0] cur_q;
  logic       cur_q_known = 1'b0;

  tt_um_shift_reg #(.WIDTH(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  // One clock of stimulus. exp_q is the register value required after the
  // edge; serial_out is also checked before the edge against the last
  // known register value.
  task automatic step(input logic r, input logic e, input logic ld,
                      input logic dir, input logic sin, input logic [3:0] d,
                      input logic [3:0] exp_q, input string tag);
    logic       pre_so;
    logic [7:0] popped;
    @(negedge clk);
    reset  = r;
    ena    = e;
    ui_in  = {1'($urandom_range(1)), d, sin, dir, ld};
    uio_in = 8'($urandom);
    #1;
    if (cur_q_known) begin
      pre_so = dir ? cur_q[3] : cur_q[0];
      checks++;
      assert (uo_out[4] === pre_so)
        else begin
          errors++;
          $error("FAIL %s serial_out_pre: got %b expected %b", tag, uo_out[4], pre_so);
        end
    end
    sb_q.push_back({3'b000, (dir ? exp_q[3] : exp_q[0]), exp_q});
    @(posedge clk);
    #1;
    popped   = sb_q.pop_front();
    got_byte = uo_out;
    checks++;
    assert (got_byte === popped)
      else begin
        errors++;
        $error("FAIL %s uo_out: got %h expected %h", tag, got_byte, popped);
      end
    checks++;
    assert ({uio_out, uio_oe} === 16'h0000)
      else begin
        errors++;
        $error("FAIL %s uio: got out=%h oe=%h expected 00/00", tag, uio_out, uio_oe);
      end
    cur_q       = exp_q;
    cur_q_known = 1'b1;
  endtask

  initial begin
    reset  = 1'b1;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;

    // Reset with arbitrary ui_in
    step(1, 1, 1, 1, 1, 4'b1010, 4'b0000, "reset");

    // Load 1011 then shift right with sin=1
    step(0, 1, 1, 0, 0, 4'b1011, 4'b1011, "load1011");
    step(0, 1, 0, 0, 1, 4'b0000, 4'b1101, "shr1");
    step(0, 1, 0, 0, 1, 4'b0110, 4'b1110, "shr2");
    step(0, 1, 0, 0, 1, 4'b0000, 4'b1111, "shr3");
    step(0, 1, 0, 0, 1, 4'b1001, 4'b1111, "shr4");

    // Shift left with sin=0
    step(0, 1, 0, 1, 0, 4'b0000, 4'b1110, "shl1");
    step(0, 1, 0, 1, 0, 4'b1111, 4'b1100, "shl2");
    step(0, 1, 0, 1, 0, 4'b0000, 4'b1000, "shl3");
    step(0, 1, 0, 1, 0, 4'b0101, 4'b0000, "shl4");

    // Load 1100 then shift right twice
    step(0, 1, 1, 1, 0, 4'b1100, 4'b1100, "load1100");
    step(0, 1, 0, 0, 1, 4'b0000, 4'b1110, "shr5");
    step(0, 1, 0, 0, 1, 4'b0000, 4'b1111, "shr6");

    // Hold with ena=0 while load/shift toggle
    step(0, 1, 1, 0, 0, 4'b1011, 4'b1011, "load1011b");
    step(0, 0, 1, 0, 1, 4'b0000, 4'b1011, "hold1");
    step(0, 0, 0, 1, 1, 4'b0110, 4'b1011, "hold2");
    step(0, 0, 0, 0, 0, 4'b1111, 4'b1011, "hold3");

    // Reset wins over load
    step(1, 1, 1, 0, 0, 4'b1111, 4'b0000, "reset_load");

    // Reset mid-shift, then resume shifting left from zero
    step(0, 1, 1, 0, 0, 4'b1010, 4'b1010, "load1010");
    step(0, 1, 0, 0, 1, 4'b0000, 4'b1101, "shr7");
    step(1, 1, 0, 0, 1, 4'b0000, 4'b0000, "reset_mid");
    step(0, 1, 0, 1, 1, 4'b0000, 4'b0001, "shl5");
    step(0, 1, 0, 1, 1, 4'b0000, 4'b0011, "shl6");

    // Left shift of a loaded pattern, with serial_out following direction
    step(0, 1, 1, 1, 0, 4'b1001, 4'b1001, "load1001");
    step(0, 1, 0, 1, 0, 4'b0000, 4'b0010, "shl7");
    step(0, 1, 0, 0, 0, 4'b0000, 4'b0001, "shr8");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
